// File: rtl/keycode_motion_ctrl_if.sv
// Keycode-to-motion bus: frame pacing and raw keycode in, filtered key and
// game controls out.
interface keycode_motion_ctrl_if #(
  parameter int VW = 8
);
  logic                 frame_tick;
  logic [7:0]           keycode;
  logic [7:0]           key_filtered;
  logic signed [VW-1:0] velocity_x;
  logic [1:0]           move_state;
  logic                 paused;
  logic                 restart_pulse;

  modport master (
    output frame_tick, keycode,
    input  key_filtered, velocity_x, move_state, paused, restart_pulse
  );

  modport slave (
    input  frame_tick, keycode,
    output key_filtered, velocity_x, move_state, paused, restart_pulse
  );
endinterface

// File: rtl/keycode_motion_ctrl.sv
// Keycode deglitcher and doodler motion controller: turns the SoC keycode
// into a debounced key, a frame-paced horizontal velocity with acceleration
// and friction, a pause level and a restart pulse.
module keycode_motion_ctrl #(
  parameter logic [7:0] KEY_LEFT    = 8'h04,
  parameter logic [7:0] KEY_RIGHT   = 8'h07,
  parameter logic [7:0] KEY_PAUSE   = 8'h2C,
  parameter logic [7:0] KEY_RESTART = 8'h15,
  parameter int         DEB_CYCLES  = 4,
  parameter int         VW          = 8,
  parameter int         VMAX        = 6,
  parameter int         ACCEL       = 1,
  parameter int         FRIC        = 1
) (
  input logic                  Clk,
  input logic                  Reset,
  keycode_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_L = 2'd1,
    ACC_R = 2'd2,
    COAST = 2'd3
  } state_t;

  // One guard bit so accelerate/decay never wraps before clamping.
  localparam int SW = VW + 1;
  localparam logic signed [SW-1:0] VMAX_S  = SW'(VMAX);
  localparam logic signed [SW-1:0] ACCEL_S = SW'(ACCEL);
  localparam logic signed [SW-1:0] FRIC_S  = SW'(FRIC);
  localparam logic [3:0] STAB_MAX  = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] STAB_FIRE = 4'(DEB_CYCLES - 2);

  logic [7:0]           kc_q;
  logic [7:0]           kc_prev;
  logic [3:0]           stab;
  logic [7:0]           key_filtered;
  logic [7:0]           kf_d;
  logic signed [VW-1:0] velocity_x;
  state_t               state;
  logic                 paused;
  logic                 restart_pulse;

  logic                 new_key;
  logic                 pause_evt;
  logic                 restart_evt;
  logic signed [SW-1:0] vel_ext;
  logic signed [VW-1:0] vel_left;
  logic signed [VW-1:0] vel_right;
  logic signed [VW-1:0] vel_fric;

  // Symmetric saturation to +/-VMAX, then narrow back to the output width.
  function automatic logic signed [VW-1:0] clamp_vel(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] t;
    t = v;
    if (t > VMAX_S)
      t = VMAX_S;
    else if (t < -VMAX_S)
      t = -VMAX_S;
    return t[VW-1:0];
  endfunction

  // Friction: step toward zero by FRIC, never crossing zero.
  function automatic logic signed [VW-1:0] decay_vel(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] t;
    t = '0;
    if (v > 0) begin
      t = v - FRIC_S;
      if (t < 0)
        t = '0;
    end else if (v < 0) begin
      t = v + FRIC_S;
      if (t > 0)
        t = '0;
    end
    return t[VW-1:0];
  endfunction

  // Stage 0/1: register raw keycode, count stable samples, publish filtered key.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q         <= '0;
      kc_prev      <= '0;
      stab         <= '0;
      key_filtered <= '0;
      kf_d         <= '0;
    end else begin
      kc_q <= bus.keycode;
      kf_d <= key_filtered;
      if (kc_q != kc_prev) begin
        kc_prev <= kc_q;
        stab    <= '0;
      end else begin
        if (stab != STAB_MAX)
          stab <= stab + 4'd1;
        if (stab == STAB_FIRE)
          key_filtered <= kc_prev;
      end
    end
  end

  assign new_key     = (key_filtered != kf_d);
  assign pause_evt   = new_key && (key_filtered == KEY_PAUSE);
  assign restart_evt = new_key && (key_filtered == KEY_RESTART);

  assign vel_ext   = {velocity_x[VW-1], velocity_x};
  assign vel_left  = clamp_vel(vel_ext - ACCEL_S);
  assign vel_right = clamp_vel(vel_ext + ACCEL_S);
  assign vel_fric  = decay_vel(vel_ext);

  // Stage 2: motion FSM; restart wins over frame tick, pause freezes motion.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      velocity_x    <= '0;
      state         <= IDLE;
      paused        <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      restart_pulse <= restart_evt;
      if (restart_evt) begin
        velocity_x <= '0;
        state      <= IDLE;
        paused     <= 1'b0;
      end else begin
        if (pause_evt)
          paused <= ~paused;
        if (bus.frame_tick && !paused) begin
          if (key_filtered == KEY_LEFT) begin
            velocity_x <= vel_left;
            state      <= ACC_L;
          end else if (key_filtered == KEY_RIGHT) begin
            velocity_x <= vel_right;
            state      <= ACC_R;
          end else begin
            velocity_x <= vel_fric;
            state      <= (vel_fric == '0) ? IDLE : COAST;
          end
        end
      end
    end
  end

  assign bus.key_filtered  = key_filtered;
  assign bus.velocity_x    = velocity_x;
  assign bus.move_state    = state;
  assign bus.paused        = paused;
  assign bus.restart_pulse = restart_pulse;

endmodule

// File: tb/tb_keycode_motion_ctrl.sv
// Bench for keycode_motion_ctrl: directed scenarios plus random keycode
// traffic, every output compared each cycle against a behavioural model.
module tb_keycode_motion_ctrl;

  localparam int DEB  = 4;
  localparam int VMAX = 6;
  localparam int KL = 8'h04, KR = 8'h07, KP = 8'h2C, KRS = 8'h15;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  keycode_motion_ctrl_if #(.VW(8)) bus ();

  keycode_motion_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit auto_tick = 1'b0;
  int tcnt = 0;

  // Behavioural model state
  int hist[$];
  int m_kf, m_kfd, m_vel, m_state;
  bit m_paused, m_rp;
  bit nk, rs, pz, stable;
  int nkf;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: a code is accepted once the last DEB raw samples all agree;
  // velocity follows the accelerate / friction / clamp rules per tick.
  always @(posedge Clk) begin
    if (Reset) begin
      m_kf = 0; m_kfd = 0; m_vel = 0; m_state = 0; m_paused = 0; m_rp = 0;
      hist.delete();
      for (int i = 0; i < DEB; i++) hist.push_back(0);
    end else begin
      nk = (m_kf != m_kfd);
      rs = nk && (m_kf == KRS);
      pz = nk && (m_kf == KP);
      stable = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
      nkf = stable ? hist[0] : m_kf;
      hist.push_back(int'(bus.keycode));
      void'(hist.pop_front());
      m_rp = rs;
      if (rs) begin
        m_vel = 0; m_state = 0; m_paused = 0;
      end else begin
        if (bus.frame_tick && !m_paused) begin
          if (m_kf == KL) begin
            m_vel = (m_vel - 1 < -VMAX) ? -VMAX : m_vel - 1;
            m_state = 1;
          end else if (m_kf == KR) begin
            m_vel = (m_vel + 1 > VMAX) ? VMAX : m_vel + 1;
            m_state = 2;
          end else begin
            if (m_vel > 0) m_vel = m_vel - 1;
            else if (m_vel < 0) m_vel = m_vel + 1;
            m_state = (m_vel == 0) ? 0 : 3;
          end
        end
        if (pz) m_paused = !m_paused;
      end
      m_kfd = m_kf;
      m_kf = nkf;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("kf", int'(bus.key_filtered), m_kf);
      chk("vel", int'(bus.velocity_x), m_vel);
      chk("state", int'(bus.move_state), m_state);
      chk("paused", int'(bus.paused), int'(m_paused));
      chk("restart", int'(bus.restart_pulse), int'(m_rp));
    end
  end

  task automatic step(input int n, input bit tk = 1'b0);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = (auto_tick && (tcnt % 10 == 9)) || tk;
      tcnt++;
      @(posedge Clk);
      #1;
    end
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    bus.keycode = 8'h00;
    bus.frame_tick = 1'b0;
    Reset = 1'b1;
    step(3);
    chk_en = 1'b1;
    chk("rst_kf", int'(bus.key_filtered), 0);
    chk("rst_vel", int'(bus.velocity_x), 0);
    chk("rst_state", int'(bus.move_state), 0);
    chk("rst_paused", int'(bus.paused), 0);
    chk("rst_restart", int'(bus.restart_pulse), 0);
    Reset = 1'b0;

    // Hold LEFT: accelerate to -VMAX and saturate
    auto_tick = 1'b1;
    bus.keycode = 8'h04;
    step(4);
    chk("t1_kf_early", int'(bus.key_filtered), 0);
    step(1);
    chk("t1_kf_5cyc", int'(bus.key_filtered), KL);
    step(75);
    chk("t1_vel_sat", int'(bus.velocity_x), -6);
    chk("t1_state", int'(bus.move_state), 1);

    // Release: coast back to zero without overshoot
    bus.keycode = 8'h00;
    step(80);
    chk("t2_vel", int'(bus.velocity_x), 0);
    chk("t2_state", int'(bus.move_state), 0);

    // Short glitch is discarded
    bus.keycode = 8'h07;
    step(3);
    bus.keycode = 8'h00;
    step(30);
    chk("t3_kf", int'(bus.key_filtered), 0);
    chk("t3_vel", int'(bus.velocity_x), 0);

    // Build +3 with manual ticks, then pause and hold
    auto_tick = 1'b0;
    bus.keycode = 8'h07;
    step(6);
    repeat (3) step(1, 1'b1);
    chk("t4_vel3", int'(bus.velocity_x), 3);
    bus.keycode = 8'h2C;
    step(7);
    chk("t4_paused", int'(bus.paused), 1);
    auto_tick = 1'b1;
    step(100);
    chk("t4_hold_paused", int'(bus.paused), 1);
    chk("t4_frozen", int'(bus.velocity_x), 3);
    bus.keycode = 8'h00;
    step(50);
    chk("t4_rel_frozen", int'(bus.velocity_x), 3);
    bus.keycode = 8'h2C;
    step(20);
    chk("t4_unpaused", int'(bus.paused), 0);
    bus.keycode = 8'h00;
    step(100);
    chk("t4_resume_vel", int'(bus.velocity_x), 0);

    // Restart while paused, coincident with a frame tick
    auto_tick = 1'b0;
    bus.keycode = 8'h07;
    step(6);
    repeat (4) step(1, 1'b1);
    chk("t5_vel4", int'(bus.velocity_x), 4);
    bus.keycode = 8'h2C;
    step(7);
    chk("t5_paused", int'(bus.paused), 1);
    bus.keycode = 8'h15;
    step(5);
    chk("t5_no_pulse_yet", int'(bus.restart_pulse), 0);
    step(1, 1'b1);
    chk("t5_pulse", int'(bus.restart_pulse), 1);
    chk("t5_vel", int'(bus.velocity_x), 0);
    chk("t5_paused0", int'(bus.paused), 0);
    chk("t5_state", int'(bus.move_state), 0);
    step(1);
    chk("t5_pulse_end", int'(bus.restart_pulse), 0);

    // Reset mid-operation, key held through it
    bus.keycode = 8'h07;
    step(6);
    repeat (6) step(1, 1'b1);
    chk("t6_vel6", int'(bus.velocity_x), 6);
    bus.keycode = 8'h2C;
    step(7);
    chk("t6_paused", int'(bus.paused), 1);
    bus.keycode = 8'h07;
    step(10);
    Reset = 1'b1;
    step(1);
    chk("t6_kf", int'(bus.key_filtered), 0);
    chk("t6_vel", int'(bus.velocity_x), 0);
    chk("t6_state", int'(bus.move_state), 0);
    chk("t6_paused0", int'(bus.paused), 0);
    chk("t6_restart", int'(bus.restart_pulse), 0);
    Reset = 1'b0;
    step(4);
    chk("t6_kf_deb", int'(bus.key_filtered), 0);
    step(1);
    chk("t6_kf_back", int'(bus.key_filtered), KR);

    // Random keycode traffic with occasional resets
    auto_tick = 1'b1;
    for (int it = 0; it < 1200; it++) begin
      case ($urandom_range(0, 5))
        0: bus.keycode = 8'h00;
        1: bus.keycode = 8'h04;
        2: bus.keycode = 8'h07;
        3: bus.keycode = 8'h2C;
        4: bus.keycode = 8'h15;
        default: bus.keycode = 8'($urandom_range(0, 255));
      endcase
      Reset = ($urandom_range(0, 99) == 0);
      step(1);
      Reset = 1'b0;
      step($urandom_range(0, 29));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
